// File: rtl/reset_controller.sv
// Reset sequencer: stretches external, watchdog and software resets, masks the watchdog
// during a post-reset holdoff window, and locks the system in reset after repeated watchdog trips.
module reset_controller #(
  parameter int unsigned RESET_CYCLES   = 8,
  parameter int unsigned HOLDOFF_CYCLES = 16,
  parameter int unsigned LOCK_THRESH    = 4,
  parameter int unsigned CLEAN_CYCLES   = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wdt_reset,
  input  logic       i_sw_reset,
  input  logic       i_clear_lockout,
  output logic       o_sys_reset,
  output logic       o_wdt_enable,
  output logic [1:0] o_cause,
  output logic [3:0] o_wdt_count,
  output logic       o_lockout
);

  localparam int unsigned PhaseMax = (RESET_CYCLES > HOLDOFF_CYCLES) ? RESET_CYCLES
                                                                     : HOLDOFF_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned CleanW   = $clog2(CLEAN_CYCLES + 1);
  localparam int unsigned ConsecW  = $clog2(LOCK_THRESH + 1);

  localparam logic [1:0] CauseExt = 2'b00;
  localparam logic [1:0] CauseWdt = 2'b01;
  localparam logic [1:0] CauseSw  = 2'b10;

  typedef enum logic [1:0] {StReset, StHoldoff, StRun, StLocked} state_e;

  state_e              state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [CleanW-1:0]   clean_q, clean_d;
  logic [ConsecW-1:0]  consec_q, consec_d;
  logic [1:0]          cause_q, cause_d;
  logic [3:0]          wdt_cnt_q, wdt_cnt_d;
  logic                sys_reset_q, wdt_en_q, lockout_q;

  logic [PhaseW-1:0]   phase_inc;
  logic [CleanW-1:0]   clean_inc;
  logic [ConsecW-1:0]  consec_inc;

  assign phase_inc  = phase_q + PhaseW'(1);
  assign clean_inc  = clean_q + CleanW'(1);
  assign consec_inc = consec_q + ConsecW'(1);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    clean_d   = clean_q;
    consec_d  = consec_q;
    cause_d   = cause_q;
    wdt_cnt_d = wdt_cnt_q;

    unique case (state_q)
      StReset: begin
        // Requests are ignored here so the stretch can never be extended.
        if (phase_q == PhaseW'(RESET_CYCLES - 1)) begin
          state_d = StHoldoff;
          phase_d = '0;
        end else begin
          phase_d = phase_inc;
        end
      end

      StHoldoff: begin
        if (i_sw_reset) begin
          state_d = StReset;
          phase_d = '0;
          clean_d = '0;
          cause_d = CauseSw;
        end else if (phase_q == PhaseW'(HOLDOFF_CYCLES - 1)) begin
          state_d = StRun;
          phase_d = '0;
        end else begin
          phase_d = phase_inc;
        end
      end

      StRun: begin
        if (i_wdt_reset) begin
          // A simultaneous software request is absorbed into the watchdog event.
          cause_d  = CauseWdt;
          consec_d = consec_inc;
          clean_d  = '0;
          phase_d  = '0;
          if (wdt_cnt_q != 4'hF) begin
            wdt_cnt_d = wdt_cnt_q + 4'd1;
          end
          state_d = (consec_inc == ConsecW'(LOCK_THRESH)) ? StLocked : StReset;
        end else if (i_sw_reset) begin
          cause_d = CauseSw;
          clean_d = '0;
          phase_d = '0;
          state_d = StReset;
        end else if (clean_q != CleanW'(CLEAN_CYCLES)) begin
          clean_d = clean_inc;
          if (clean_inc == CleanW'(CLEAN_CYCLES)) begin
            consec_d = '0;
          end
        end
      end

      StLocked: begin
        if (i_clear_lockout) begin
          state_d  = StReset;
          phase_d  = '0;
          clean_d  = '0;
          consec_d = '0;
        end
      end

      default: begin
        state_d = StReset;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StReset;
      phase_q     <= '0;
      clean_q     <= '0;
      consec_q    <= '0;
      cause_q     <= CauseExt;
      wdt_cnt_q   <= '0;
      sys_reset_q <= 1'b1;
      wdt_en_q    <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      clean_q     <= clean_d;
      consec_q    <= consec_d;
      cause_q     <= cause_d;
      wdt_cnt_q   <= wdt_cnt_d;
      // Outputs are registered from the next state so they track state_q exactly.
      sys_reset_q <= (state_d == StReset) || (state_d == StLocked);
      wdt_en_q    <= (state_d == StRun);
      lockout_q   <= (state_d == StLocked);
    end
  end

  assign o_sys_reset  = sys_reset_q;
  assign o_wdt_enable = wdt_en_q;
  assign o_cause      = cause_q;
  assign o_wdt_count  = wdt_cnt_q;
  assign o_lockout    = lockout_q;

endmodule

// File: tb/tb_reset_controller.sv
// Bench for reset_controller: stimulus queues the expected output changes with their cycle
// numbers; a monitor compares every observed output change against the queue head.
module tb_reset_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       wdt_reset;
  logic       sw_reset;
  logic       clear_lockout;
  logic       sys_reset;
  logic       wdt_enable;
  logic [1:0] cause;
  logic [3:0] wdt_count;
  logic       lockout;

  reset_controller #(
    .RESET_CYCLES   (8),
    .HOLDOFF_CYCLES (16),
    .LOCK_THRESH    (4),
    .CLEAN_CYCLES   (64)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wdt_reset     (wdt_reset),
    .i_sw_reset      (sw_reset),
    .i_clear_lockout (clear_lockout),
    .o_sys_reset     (sys_reset),
    .o_wdt_enable    (wdt_enable),
    .o_cause         (cause),
    .o_wdt_count     (wdt_count),
    .o_lockout       (lockout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } ev_t;

  ev_t        sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] prev_v = 'x;
  logic [8:0] mon_v;
  ev_t        mon_e;

  // Bench model of the architectural counters.
  logic [1:0] exp_cause = 2'b00;
  int         exp_cnt = 0;
  int         exp_consec = 0;
  int         run_at = 0;
  bit         locked = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output vector must match the next queued event.
  always @(negedge clk) begin
    mon_v = {sys_reset, wdt_enable, cause, wdt_count, lockout};
    if (mon_v !== prev_v) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, mon_v);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || mon_e.v !== mon_v) begin
          n_fail++;
          $display("FAIL out_event got cyc=%0d val=%b required cyc=%0d val=%b",
                   cyc, mon_v, mon_e.cyc, mon_e.v);
        end
      end
      prev_v = mon_v;
    end
  end

  function automatic void push(int c, bit s, bit en, logic [1:0] ca, int cn, bit lk);
    ev_t e;
    e.cyc = c;
    e.v   = {s, en, ca, cn[3:0], lk};
    sb.push_back(e);
  endfunction

  // Full stretch + holdoff sequence for a reset entered at edge e.
  function automatic void push_seq(int e);
    push(e,      1'b1, 1'b0, exp_cause, exp_cnt, 1'b0);
    push(e + 8,  1'b0, 1'b0, exp_cause, exp_cnt, 1'b0);
    push(e + 24, 1'b0, 1'b1, exp_cause, exp_cnt, 1'b0);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int target);
    while (cyc < target) begin
      if (cyc > 20000) begin
        $display("FAIL cycle_budget cyc=%0d required<=20000", cyc);
        $fatal(1, "cycle budget exhausted");
      end
      tick(1);
    end
  endtask

  task automatic do_wdt(bit with_sw, bit poke);
    int e;
    wait_until(run_at + 5);
    wdt_reset = 1'b1;
    sw_reset  = with_sw;
    e = cyc + 1;
    exp_cause = 2'b01;
    exp_cnt   = (exp_cnt == 15) ? 15 : exp_cnt + 1;
    exp_consec++;
    if (exp_consec == 4) begin
      push(e, 1'b1, 1'b0, exp_cause, exp_cnt, 1'b1);
      locked = 1'b1;
    end else begin
      push_seq(e);
    end
    tick(1);
    wdt_reset = 1'b0;
    sw_reset  = 1'b0;
    if (!locked) begin
      if (poke) begin
        wait_until(e + 12);
        wdt_reset = 1'b1;
        tick(1);
        wdt_reset = 1'b0;
      end
      wait_until(e + 24);
      run_at = e + 24;
    end
  endtask

  task automatic do_clear();
    int e;
    clear_lockout = 1'b1;
    e = cyc + 1;
    exp_consec = 0;
    push_seq(e);
    tick(1);
    clear_lockout = 1'b0;
    locked = 1'b0;
    wait_until(e + 24);
    run_at = e + 24;
  endtask

  initial begin
    int e, e2, r1;
    rst = 1'b1;
    wdt_reset = 1'b0;
    sw_reset = 1'b0;
    clear_lockout = 1'b0;

    // Power-on: reset held for edges 1..3.
    push(1, 1'b1, 1'b0, 2'b00, 0, 1'b0);
    tick(3);
    rst = 1'b0;
    push(11, 1'b0, 1'b0, 2'b00, 0, 1'b0);
    push(27, 1'b0, 1'b1, 2'b00, 0, 1'b0);
    wait_until(27);
    run_at = 27;

    // Single watchdog event, with a second pulse during holdoff.
    do_wdt(1'b0, 1'b1);
    // Watchdog and software together: watchdog wins.
    do_wdt(1'b1, 1'b0);

    // Software reset in RUN, requests during RESET, software reset in HOLDOFF.
    wait_until(run_at + 5);
    sw_reset = 1'b1;
    e = cyc + 1;
    exp_cause = 2'b10;
    push(e,     1'b1, 1'b0, exp_cause, exp_cnt, 1'b0);
    push(e + 8, 1'b0, 1'b0, exp_cause, exp_cnt, 1'b0);
    tick(1);
    sw_reset = 1'b0;
    wait_until(e + 3);
    sw_reset = 1'b1;
    wdt_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    wdt_reset = 1'b0;
    wait_until(e + 13);
    sw_reset = 1'b1;
    e2 = cyc + 1;
    push_seq(e2);
    tick(1);
    sw_reset = 1'b0;
    wait_until(e2 + 24);
    run_at = e2 + 24;

    // Watchdog event, then external reset mid-holdoff.
    wait_until(run_at + 5);
    wdt_reset = 1'b1;
    e = cyc + 1;
    exp_cause = 2'b01;
    exp_cnt++;
    push(e,     1'b1, 1'b0, exp_cause, exp_cnt, 1'b0);
    push(e + 8, 1'b0, 1'b0, exp_cause, exp_cnt, 1'b0);
    tick(1);
    wdt_reset = 1'b0;
    wait_until(e + 14);
    rst = 1'b1;
    r1 = cyc + 1;
    exp_cause = 2'b00;
    exp_cnt = 0;
    exp_consec = 0;
    push(r1, 1'b1, 1'b0, 2'b00, 0, 1'b0);
    tick(2);
    rst = 1'b0;
    push(r1 + 9,  1'b0, 1'b0, 2'b00, 0, 1'b0);
    push(r1 + 25, 1'b0, 1'b1, 2'b00, 0, 1'b0);
    wait_until(r1 + 25);
    run_at = r1 + 25;

    // Lockout after four consecutive watchdog resets; requests ignored while locked.
    repeat (4) do_wdt(1'b0, 1'b0);
    tick(40);
    wdt_reset = 1'b1;
    sw_reset = 1'b1;
    tick(3);
    wdt_reset = 1'b0;
    sw_reset = 1'b0;
    tick(57);
    do_clear();

    // Clean run clears the consecutive count.
    repeat (3) do_wdt(1'b0, 1'b0);
    wait_until(run_at + 70);
    exp_consec = 0;
    repeat (3) do_wdt(1'b0, 1'b0);

    // Saturation of the total count across repeated lockouts.
    repeat (12) begin
      do_wdt(1'b0, 1'b0);
      if (locked) begin
        tick(10);
        do_clear();
      end
    end

    tick(5);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events got=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
